// File: rtl/bus_cycle_ctrl.sv
// 68000 bus cycle controller. It decodes a synchronised address strobe into chip
// selects and read/write enables, then terminates the cycle with DTACK, AVEC or BERR.
module bus_cycle_ctrl #(
  parameter int ROM_WAIT     = 2,
  parameter int RAM_WAIT     = 1,
  parameter int BERR_TIMEOUT = 64
) (
  input  logic        sysclk,
  input  logic        sysrst_n,
  input  logic        as_n,
  input  logic        w_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic [23:0] logaddr,
  input  logic [2:0]  fc,
  output logic        csrom_n,
  output logic        csram1_n,
  output logic        csram2_n,
  output logic        re_n,
  output logic        we_n,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        avec_n,
  output logic [1:0]  o_dbg_state,
  output logic [23:0] o_dbg_addr
);

  // Handshake: the CPU opens a cycle by pulling as_n low and holds it until a
  // termination (dtack_n/avec_n/berr_n) is low; the cycle closes when as_n rises,
  // at which point every output returns high. Releasing as_n early aborts the cycle.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2, S_FAULT = 2'd3} state_t;
  typedef enum logic [2:0] {K_ROM, K_RAM1, K_RAM2, K_UNMAP, K_IACK} kind_t;

  state_t      r_state, w_nxt_state;
  kind_t       r_kind, w_nxt_kind;
  logic [7:0]  r_cnt, w_nxt_cnt;
  logic [23:0] r_addr, w_nxt_addr;
  logic        r_as_meta, r_as_s;
  logic [1:0]  r_boot;
  logic        r_armed, w_nxt_armed;
  logic        r_csrom_n, r_csram1_n, r_csram2_n, r_re_n, r_we_n;
  logic        r_dtack_n, r_berr_n, r_avec_n;
  logic        w_csrom_n, w_csram1_n, w_csram2_n, w_re_n, w_we_n;
  logic        w_dtack_n, w_berr_n, w_avec_n;

  // r_boot keeps the FSM from arming until reset values have flushed the synchroniser.
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      r_as_meta  <= 1'b1;
      r_as_s     <= 1'b1;
      r_boot     <= 2'b00;
      r_state    <= S_IDLE;
      r_kind     <= K_ROM;
      r_cnt      <= 8'd0;
      r_addr     <= 24'd0;
      r_armed    <= 1'b0;
      r_csrom_n  <= 1'b1;
      r_csram1_n <= 1'b1;
      r_csram2_n <= 1'b1;
      r_re_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_dtack_n  <= 1'b1;
      r_berr_n   <= 1'b1;
      r_avec_n   <= 1'b1;
    end else begin
      r_as_meta  <= as_n;
      r_as_s     <= r_as_meta;
      r_boot     <= {r_boot[0], 1'b1};
      r_state    <= w_nxt_state;
      r_kind     <= w_nxt_kind;
      r_cnt      <= w_nxt_cnt;
      r_addr     <= w_nxt_addr;
      r_armed    <= w_nxt_armed;
      r_csrom_n  <= w_csrom_n;
      r_csram1_n <= w_csram1_n;
      r_csram2_n <= w_csram2_n;
      r_re_n     <= w_re_n;
      r_we_n     <= w_we_n;
      r_dtack_n  <= w_dtack_n;
      r_berr_n   <= w_berr_n;
      r_avec_n   <= w_avec_n;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_kind  = r_kind;
    w_nxt_cnt   = r_cnt;
    w_nxt_addr  = r_addr;
    w_nxt_armed = r_armed;
    w_csrom_n   = r_csrom_n;
    w_csram1_n  = r_csram1_n;
    w_csram2_n  = r_csram2_n;
    w_re_n      = r_re_n;
    w_we_n      = r_we_n;
    w_dtack_n   = r_dtack_n;
    w_berr_n    = r_berr_n;
    w_avec_n    = r_avec_n;
    case (r_state)
      S_IDLE: begin
        if (r_as_s) begin
          w_nxt_armed = r_boot[1];
        end else if (r_armed) begin
          w_nxt_armed = 1'b0;
          w_nxt_addr  = logaddr;
          w_nxt_state = S_WAIT;
          if (fc == 3'b111) begin
            w_nxt_kind = K_IACK;
            w_nxt_cnt  = 8'd0;
          end else begin
            case (logaddr[23:20])
              4'h0: begin
                w_nxt_kind = K_ROM;
                w_nxt_cnt  = 8'(ROM_WAIT);
                w_csrom_n  = 1'b0;
              end
              4'h1: begin
                w_nxt_kind = K_RAM1;
                w_nxt_cnt  = 8'(RAM_WAIT);
                w_csram1_n = 1'b0;
              end
              4'h2: begin
                w_nxt_kind = K_RAM2;
                w_nxt_cnt  = 8'(RAM_WAIT);
                w_csram2_n = 1'b0;
              end
              default: begin
                w_nxt_kind = K_UNMAP;
                w_nxt_cnt  = 8'(BERR_TIMEOUT - 1);
              end
            endcase
            if (logaddr[23:20] <= 4'h2) begin
              w_re_n = ~w_n;
              w_we_n = ~(~w_n & (~uds_n | ~lds_n));
            end
          end
        end
      end
      S_WAIT: begin
        if (r_as_s) begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = 8'd0;
          w_csrom_n   = 1'b1;
          w_csram1_n  = 1'b1;
          w_csram2_n  = 1'b1;
          w_re_n      = 1'b1;
          w_we_n      = 1'b1;
        end else if (r_cnt == 8'd0) begin
          case (r_kind)
            K_IACK: begin
              w_avec_n    = 1'b0;
              w_nxt_state = S_ACK;
            end
            K_UNMAP: begin
              w_berr_n    = 1'b0;
              w_nxt_state = S_FAULT;
            end
            default: begin
              w_dtack_n   = 1'b0;
              w_nxt_state = S_ACK;
            end
          endcase
        end else begin
          w_nxt_cnt = r_cnt - 8'd1;
        end
      end
      default: begin
        if (r_as_s) begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = 8'd0;
          w_csrom_n   = 1'b1;
          w_csram1_n  = 1'b1;
          w_csram2_n  = 1'b1;
          w_re_n      = 1'b1;
          w_we_n      = 1'b1;
          w_dtack_n   = 1'b1;
          w_berr_n    = 1'b1;
          w_avec_n    = 1'b1;
        end
      end
    endcase
  end

  assign csrom_n     = r_csrom_n;
  assign csram1_n    = r_csram1_n;
  assign csram2_n    = r_csram2_n;
  assign re_n        = r_re_n;
  assign we_n        = r_we_n;
  assign dtack_n     = r_dtack_n;
  assign berr_n      = r_berr_n;
  assign avec_n      = r_avec_n;
  assign o_dbg_state = r_state;
  assign o_dbg_addr  = r_addr;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: ROM/RAM/unmapped/IACK cycles, abort and reset in WAIT.
module tb_bus_cycle_ctrl;

  logic        sysclk = 1'b0;
  logic        sysrst_n, as_n, w_n, uds_n, lds_n;
  logic [23:0] logaddr;
  logic [2:0]  fc;
  logic        csrom_n, csram1_n, csram2_n, re_n, we_n, dtack_n, berr_n, avec_n;
  logic [1:0]  dbg_state;
  logic [23:0] dbg_addr;
  logic        csrom5_n, csram15_n, csram25_n, re5_n, we5_n, dtack5_n, berr5_n, avec5_n;
  logic [1:0]  dbg_state5;
  logic [23:0] dbg_addr5;
  logic [7:0]  outs, outs5;
  int          checks = 0;
  int          errors = 0;

  assign outs  = {csrom_n, csram1_n, csram2_n, re_n, we_n, dtack_n, berr_n, avec_n};
  assign outs5 = {csrom5_n, csram15_n, csram25_n, re5_n, we5_n, dtack5_n, berr5_n, avec5_n};

  bus_cycle_ctrl u_dut (
    .sysclk(sysclk), .sysrst_n(sysrst_n), .as_n(as_n), .w_n(w_n), .uds_n(uds_n), .lds_n(lds_n),
    .logaddr(logaddr), .fc(fc), .csrom_n(csrom_n), .csram1_n(csram1_n), .csram2_n(csram2_n),
    .re_n(re_n), .we_n(we_n), .dtack_n(dtack_n), .berr_n(berr_n), .avec_n(avec_n),
    .o_dbg_state(dbg_state), .o_dbg_addr(dbg_addr)
  );

  bus_cycle_ctrl #(.ROM_WAIT(5)) u_dut5 (
    .sysclk(sysclk), .sysrst_n(sysrst_n), .as_n(as_n), .w_n(w_n), .uds_n(uds_n), .lds_n(lds_n),
    .logaddr(logaddr), .fc(fc), .csrom_n(csrom5_n), .csram1_n(csram15_n), .csram2_n(csram25_n),
    .re_n(re5_n), .we_n(we5_n), .dtack_n(dtack5_n), .berr_n(berr5_n), .avec_n(avec5_n),
    .o_dbg_state(dbg_state5), .o_dbg_addr(dbg_addr5)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives as_n low and advances to E0 (third edge: two synchroniser stages, then FSM).
  task automatic start_cycle(input string tag);
    @(negedge sysclk);
    as_n = 1'b0;
    tick();
    chk({tag, "_pre1"}, outs, 8'hFF);
    tick();
    chk({tag, "_pre2"}, outs, 8'hFF);
    tick();
  endtask

  // Releases as_n; outputs must hold for two edges, then clear on the third.
  task automatic end_cycle(input string tag, input logic [7:0] held);
    @(negedge sysclk);
    as_n = 1'b1;
    tick();
    chk({tag, "_hold1"}, outs, held);
    tick();
    chk({tag, "_hold2"}, outs, held);
    tick();
    chk({tag, "_release"}, outs, 8'hFF);
    chk({tag, "_idle"}, {6'd0, dbg_state}, 8'd0);
    repeat (3) tick();
  endtask

  initial begin
    sysrst_n = 1'b1;
    as_n     = 1'b1;
    w_n      = 1'b1;
    uds_n    = 1'b1;
    lds_n    = 1'b1;
    logaddr  = 24'h0;
    fc       = 3'b110;
    #2 sysrst_n = 1'b0;
    #1;
    chk("reset_outs", outs, 8'hFF);
    chk("reset_state", {6'd0, dbg_state}, 8'd0);
    repeat (2) tick();
    @(negedge sysclk);
    sysrst_n = 1'b1;
    repeat (4) tick();

    // ROM read, ROM_WAIT=2: dtack at E0+3; address change after E0 is ignored.
    logaddr = 24'h000400; w_n = 1'b1; uds_n = 1'b0; lds_n = 1'b0; fc = 3'b110;
    start_cycle("rom");
    chk("rom_e0", outs, 8'h6F);
    chk("rom_addr", dbg_addr[7:0], 8'h00);
    chk("rom_addr_hi", dbg_addr[15:8], 8'h04);
    logaddr = 24'h100000;
    tick();
    chk("rom_e1", outs, 8'h6F);
    tick();
    chk("rom_e2", outs, 8'h6F);
    tick();
    chk("rom_e3_dtack", outs, 8'h6B);
    chk("rom_ack_state", {6'd0, dbg_state}, 8'd2);
    end_cycle("rom", 8'h6B);

    // RAM2 write, upper strobe only: dtack at E0+2.
    logaddr = 24'h2000FE; w_n = 1'b0; uds_n = 1'b0; lds_n = 1'b1; fc = 3'b101;
    start_cycle("ram2w");
    chk("ram2w_e0", outs, 8'hD7);
    tick();
    chk("ram2w_e1", outs, 8'hD7);
    tick();
    chk("ram2w_e2_dtack", outs, 8'hD3);
    end_cycle("ram2w", 8'hD3);

    // RAM1 write with both strobes high: chip select only, no enables.
    logaddr = 24'h100010; w_n = 1'b0; uds_n = 1'b1; lds_n = 1'b1;
    start_cycle("ram1nostb");
    chk("ram1nostb_e0", outs, 8'hBF);
    tick();
    tick();
    chk("ram1nostb_dtack", outs, 8'hBB);
    end_cycle("ram1nostb", 8'hBB);

    // Unmapped read: nothing for 63 edges, berr at E0+64.
    logaddr = 24'hF00000; w_n = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
    start_cycle("unmap");
    chk("unmap_e0", outs, 8'hFF);
    for (int i = 1; i < 64; i++) begin
      tick();
      chk("unmap_wait", outs, 8'hFF);
    end
    tick();
    chk("unmap_berr", outs, 8'hFD);
    chk("unmap_fault_state", {6'd0, dbg_state}, 8'd3);
    end_cycle("unmap", 8'hFD);

    // Interrupt acknowledge: avec at E0+1 only.
    logaddr = 24'hFFFFF5; fc = 3'b111; w_n = 1'b1;
    start_cycle("iack");
    chk("iack_e0", outs, 8'hFF);
    tick();
    chk("iack_avec", outs, 8'hFE);
    end_cycle("iack", 8'hFE);

    // Abort with ROM_WAIT=5: as_n released so the FSM sees as_s=1 at E0+2.
    logaddr = 24'h000800; fc = 3'b110; w_n = 1'b1;
    @(negedge sysclk);
    as_n = 1'b0;
    tick();
    tick();
    @(negedge sysclk);
    as_n = 1'b1;
    tick();
    chk("abort_e0", outs5, 8'h6F);
    tick();
    chk("abort_e1", outs5, 8'h6F);
    tick();
    chk("abort_e2", outs5, 8'hFF);
    chk("abort_state", {6'd0, dbg_state5}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_term", outs5, 8'hFF);
    end

    // Reset during WAIT: outputs clear asynchronously, and a held as_n starts nothing.
    logaddr = 24'h000400; fc = 3'b110; w_n = 1'b1;
    start_cycle("rstw");
    chk("rstw_e0", outs, 8'h6F);
    tick();
    chk("rstw_e1", outs, 8'h6F);
    #2 sysrst_n = 1'b0;
    #1;
    chk("rstw_async", outs, 8'hFF);
    chk("rstw_state", {6'd0, dbg_state}, 8'd0);
    @(negedge sysclk);
    sysrst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rstw_held_asn", outs, 8'hFF);
    end
    @(negedge sysclk);
    as_n = 1'b1;
    repeat (4) tick();
    fc = 3'b111;
    start_cycle("rstw_new");
    tick();
    chk("rstw_new_avec", outs, 8'hFE);
    end_cycle("rstw_new", 8'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 Parameter ROM_WAIT, default 2: wait cycles for a ROM access, legal range 0-15.
REQ-002 Parameter RAM_WAIT, default 1: wait cycles for a RAM1 or RAM2 access, legal range 0-15.
REQ-003 Parameter BERR_TIMEOUT, default 64: cycles before an unmapped access faults, legal range 1-255.
REQ-004 sysclk  in  1  sole clock; every flop SHALL be clocked by it.
REQ-005 sysrst_n  in  1  reset; asynchronous, active-low.
REQ-006 as_n  in  1  68000 address strobe, asynchronous to sysclk.
REQ-007 w_n  in  1  68000 write strobe, active-low.
REQ-008 uds_n, lds_n  in  1 each  68000 upper and lower data strobes, active-low.
REQ-009 logaddr  in  24  68000 address [23:0].
REQ-010 fc  in  3  68000 function code.
REQ-011 csrom_n, csram1_n, csram2_n  out  1 each  chip selects, active-low.
REQ-012 re_n, we_n  out  1 each  memory read and write enables, active-low.
REQ-013 dtack_n, berr_n, avec_n  out  1 each  cycle terminations to the CPU, active-low.

Function
REQ-014 as_n SHALL pass through a 2-flop synchroniser; as_s denotes the synchronised value, and no other logic SHALL sample raw as_n.
REQ-015 All outputs SHALL be driven directly from flops, with no combinational path from any input.
REQ-016 The controller SHALL be an FSM with states IDLE, WAIT, ACK and FAULT.
REQ-017 Edge E0 is the first sysclk edge at which the FSM is in IDLE and as_s=0; at E0 the block SHALL capture logaddr, fc, w_n, uds_n and lds_n, and SHALL ignore them until the next return to IDLE.
REQ-018 Decode at E0 SHALL be:
 - fc=3'b111 -> IACK.
 - logaddr[23:20]=0x0 -> ROM.
 - logaddr[23:20]=0x1 -> RAM1.
 - logaddr[23:20]=0x2 -> RAM2.
 - anything else -> UNMAPPED.
REQ-019 For a mapped access (ROM, RAM1, RAM2), the matching chip select SHALL go low at E0, and the FSM SHALL enter WAIT with an 8-bit counter loaded with ROM_WAIT or RAM_WAIT.
REQ-020 re_n SHALL go low at E0 when the captured w_n=1.
REQ-021 we_n SHALL go low at E0 when the captured w_n=0 and at least one captured data strobe is low; otherwise we_n SHALL stay high.
REQ-022 In WAIT for a mapped access, the counter SHALL decrement by one per cycle; on the edge where it is 0, dtack_n SHALL go low and the FSM SHALL enter ACK, so dtack_n falls at E0+WAIT+1.
REQ-023 For IACK, no chip select, re_n or we_n SHALL assert; avec_n SHALL go low at E0+1 and the FSM SHALL enter ACK.
REQ-024 For UNMAPPED, no chip select, re_n or we_n SHALL assert, and the counter SHALL load BERR_TIMEOUT-1.
REQ-025 For UNMAPPED, berr_n SHALL go low at E0+BERR_TIMEOUT and the FSM SHALL enter FAULT; dtack_n SHALL never assert for an unmapped access.
REQ-026 In ACK or FAULT, all asserted outputs SHALL hold until as_s=1.
REQ-027 On the first edge where as_s=1 in ACK or FAULT, every output SHALL return high on that same edge and the FSM SHALL enter IDLE.
REQ-028 If as_s=1 while in WAIT (aborted cycle), all outputs SHALL go high on that edge, the FSM SHALL enter IDLE, and no termination SHALL assert.
REQ-029 Back-to-back cycles: a new E0 SHALL NOT occur until at least one cycle has elapsed in IDLE with as_s=1.
REQ-030 At most one of csrom_n, csram1_n, csram2_n SHALL be low at any time.
REQ-031 At most one of dtack_n, berr_n, avec_n SHALL be low at any time.
REQ-032 re_n and we_n SHALL never both be low.

Reset
REQ-033 While sysrst_n=0, the FSM SHALL be IDLE, the counter 0, both synchroniser flops 1, and every output 1, independent of sysclk.
REQ-034 Reset asserted mid-cycle in any state SHALL force the REQ-033 values immediately (asynchronously).
REQ-035 After sysrst_n deasserts, the first E0 SHALL NOT occur before as_s has propagated through both synchroniser stages.

Verification
REQ-036 ROM read: logaddr=0x000400, w_n=1, fc=3'b110, ROM_WAIT=2 -> csrom_n=0 and re_n=0 at E0, dtack_n=0 at E0+3; as_n released -> all outputs high once as_s=1.
REQ-037 RAM2 write: logaddr=0x2000FE, w_n=0, uds_n=0, lds_n=1, RAM_WAIT=1 -> csram2_n=0 and we_n=0 at E0, re_n stays 1, dtack_n=0 at E0+2.
REQ-038 Unmapped access: logaddr=0xF00000, BERR_TIMEOUT=64 -> all chip selects stay 1, berr_n=0 at E0+64, dtack_n stays 1 throughout.
REQ-039 IACK: fc=3'b111, logaddr=0xFFFFF5 -> avec_n=0 at E0+1; chip selects, re_n, we_n and dtack_n stay 1.
REQ-040 Abort: ROM_WAIT=5, as_n released so that as_s=1 at E0+2 -> all outputs high at that edge, dtack_n never low, FSM returns to IDLE.
REQ-041 Reset during WAIT: sysrst_n=0 at E0+1 -> all outputs 1 immediately, before the next sysclk edge; no termination afterwards until a new as_n assertion.
